// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one SRAM-style bus between instruction fetch and the mem stage
// One transaction at a time through a grant FSM, with fetch fairness and a hung-access timeout.
module mem_bus_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_stall_o,
   input  logic        dm_ce_i,
   input  logic        dm_we_i,
   input  logic [3:0]  dm_sel_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_i,
   output logic [31:0] dm_data_o,
   output logic        dm_stall_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_data_o,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_DGNT, S_IGNT, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_owner_if;
   logic              r_if_owed;
   logic [TO_W-1:0]   r_cnt;
   logic              r_bus_req;
   logic              r_bus_we;
   logic [3:0]        r_bus_sel;
   logic [31:0]       r_bus_addr;
   logic [31:0]       r_bus_data;
   logic              r_bus_err;
   logic [31:0]       r_if_data;
   logic [31:0]       r_dm_data;
   logic              w_gnt_dm;
   logic              w_gnt_if;
   logic              w_ack;
   logic              w_tmo;
   logic              w_done;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_gnt_dm = 1'b0;
      w_gnt_if = 1'b0;
      w_ack    = 1'b0;
      w_tmo    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // data wins unless a fetch was passed over last time and is still waiting
            if (dm_ce_i && !(r_if_owed && if_ce_i)) begin
               w_gnt_dm = 1'b1;
               w_next   = S_DGNT;
            end else if (if_ce_i) begin
               w_gnt_if = 1'b1;
               w_next   = S_IGNT;
            end
         end
         S_DGNT, S_IGNT: begin
            if (bus_ack_i) begin
               w_ack  = 1'b1;
               w_next = S_DONE;
            end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
               w_tmo  = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner_if <= 1'b0;
         r_if_owed  <= 1'b0;
         r_cnt      <= '0;
         r_bus_req  <= 1'b0;
         r_bus_we   <= 1'b0;
         r_bus_sel  <= 4'h0;
         r_bus_addr <= 32'h0;
         r_bus_data <= 32'h0;
         r_bus_err  <= 1'b0;
         r_if_data  <= 32'h0;
         r_dm_data  <= 32'h0;
      end else begin
         r_bus_err <= w_tmo;
         if (w_gnt_dm) begin
            r_bus_req  <= 1'b1;
            r_bus_we   <= dm_we_i;
            r_bus_sel  <= dm_sel_i;
            r_bus_addr <= dm_addr_i;
            r_bus_data <= dm_data_i;
            r_owner_if <= 1'b0;
            r_cnt      <= '0;
            if (if_ce_i) r_if_owed <= 1'b1;
         end else if (w_gnt_if) begin
            r_bus_req  <= 1'b1;
            r_bus_we   <= 1'b0;
            r_bus_sel  <= 4'hf;
            r_bus_addr <= if_addr_i;
            r_bus_data <= 32'h0;
            r_owner_if <= 1'b1;
            r_cnt      <= '0;
            r_if_owed  <= 1'b0;
         end
         if (r_state == S_DGNT || r_state == S_IGNT) r_cnt <= r_cnt + TO_W'(1);
         // a requester that dropped ce was flushed, so its returned data is discarded
         if (w_ack) begin
            r_bus_req <= 1'b0;
            if (r_owner_if) begin
               if (if_ce_i) r_if_data <= bus_data_i;
            end else if (!r_bus_we && dm_ce_i) begin
               r_dm_data <= bus_data_i;
            end
         end
         if (w_tmo) begin
            r_bus_req <= 1'b0;
            if (r_owner_if) r_if_data <= 32'h0;
            else            r_dm_data <= 32'h0;
         end
      end
   end

   assign w_done     = (r_state == S_DONE);
   assign if_stall_o = if_ce_i & ~rst & ~(w_done & r_owner_if);
   assign dm_stall_o = dm_ce_i & ~rst & ~(w_done & ~r_owner_if);
   assign if_data_o  = r_if_data;
   assign dm_data_o  = r_dm_data;
   assign bus_req_o  = r_bus_req;
   assign bus_we_o   = r_bus_we;
   assign bus_sel_o  = r_bus_sel;
   assign bus_addr_o = r_bus_addr;
   assign bus_data_o = r_bus_data;
   assign bus_err_o  = r_bus_err;

endmodule
